// File: rtl/edge_pose_interp.sv
// edge_pose_interp: walks a roadmap edge, streaming 2^STEP_SHIFT+1 evenly spaced joint-space poses
module edge_pose_interp #(
    parameter int STEPPERS_NUM = 6,
    parameter int STEP_SHIFT   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [32*STEPPERS_NUM-1:0] startPose,
    input  logic [32*STEPPERS_NUM-1:0] goalPose,
    input  logic                       edge_valid,
    output logic                       edge_ready,
    output logic [32*STEPPERS_NUM-1:0] stepperPosition,
    output logic                       pose_valid,
    input  logic                       pose_ready,
    output logic                       pose_last,
    output logic [STEP_SHIFT:0]        pose_idx,
    input  logic                       abort,
    output logic                       busy
);
    localparam int PW = 32 * STEPPERS_NUM;
    localparam int AW = 33 + STEP_SHIFT;
    localparam int IW = STEP_SHIFT + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(1) << STEP_SHIFT;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q   [STEPPERS_NUM];
    logic [AW-1:0]   acc_d   [STEPPERS_NUM];
    logic [AW-1:0]   nxt     [STEPPERS_NUM];
    logic [32:0]     delta_q [STEPPERS_NUM];
    logic [32:0]     delta_d [STEPPERS_NUM];
    logic [PW-1:0]   pos_q, pos_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            last_q, last_d;

    // Accumulator holds start*2^S + k*delta; one extra delta gives the next sample before shifting.
    for (genvar j = 0; j < STEPPERS_NUM; j++) begin : g_nxt
        assign nxt[j] = acc_q[j] + {{STEP_SHIFT{delta_q[j][32]}}, delta_q[j]};
    end

    // Next-state: capture the edge in IDLE, advance one sample per handshake in EMIT, abort wins.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        delta_d = delta_q;
        pos_d   = pos_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (edge_valid) begin
                for (int j = 0; j < STEPPERS_NUM; j++) begin
                    delta_d[j] = {goalPose[32*j+31], goalPose[32*j+:32]} - {startPose[32*j+31], startPose[32*j+:32]};
                    acc_d[j]   = {startPose[32*j+31], startPose[32*j+:32], {STEP_SHIFT{1'b0}}};
                end
                pos_d   = startPose;
                idx_d   = '0;
                last_d  = 1'b0;
                state_d = EMIT;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (pose_ready) begin
            if (last_q) begin
                state_d = IDLE;
            end else begin
                for (int j = 0; j < STEPPERS_NUM; j++) begin
                    acc_d[j]          = nxt[j];
                    pos_d[32*j+:32]   = nxt[j][STEP_SHIFT+:32];
                end
                idx_d  = idx_q + IW'(1);
                last_d = (idx_q + IW'(1)) == LAST_IDX;
            end
        end
    end

    // State and datapath registers, cleared asynchronously so a reset drops any edge in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= '{default: '0};
            delta_q <= '{default: '0};
            pos_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            delta_q <= delta_d;
            pos_q   <= pos_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign edge_ready      = state_q == IDLE;
    assign pose_valid      = state_q == EMIT;
    assign busy            = state_q != IDLE;
    assign pose_last       = last_q & (state_q == EMIT);
    assign pose_idx        = idx_q;
    assign stepperPosition = pos_q;
endmodule

// File: doc/edge_pose_interp.md
Name: edge_pose_interp

Overview:
Upstream neighbour of the pose-to-grid occupancy stage. Accepts one PRM roadmap edge, given as a start and goal joint-space pose (STEPPERS_NUM signed 32-bit stepper positions each). Emits 2^STEP_SHIFT+1 evenly spaced intermediate poses, start through goal inclusive, on a valid/ready stream. That stream drives the stepperPosition input of the grid stage for edge collision checking. An abort input lets downstream collision logic kill the current edge early.

Parameters:
STEPPERS_NUM, 6, number of joints; each pose is 32*STEPPERS_NUM bits, joint j at bits [32*j+31:32*j].
STEP_SHIFT, 4, log2 of segment count; the block emits 2^STEP_SHIFT+1 samples per edge.

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  reset, asynchronous, active-high.
startPose  in  32*STEPPERS_NUM  edge start pose, signed per joint.
goalPose  in  32*STEPPERS_NUM  edge goal pose, signed per joint.
edge_valid  in  1  edge request valid.
edge_ready  out  1  block can accept an edge.
stepperPosition  out  32*STEPPERS_NUM  current sample pose (registered).
pose_valid  out  1  stepperPosition holds a valid sample.
pose_ready  in  1  downstream accepts sample.
pose_last  out  1  current sample is the goal (final) sample.
pose_idx  out  STEP_SHIFT+1  index k of current sample, 0..2^STEP_SHIFT.
abort  in  1  terminate current edge.
busy  out  1  edge in progress (state != IDLE).

Behaviour:
- Reset (async, RST=1): state=IDLE.
  - Output reset values: edge_ready=1, pose_valid=0, pose_last=0, busy=0, pose_idx=0, stepperPosition=0.
  - All internal accumulators and deltas are cleared.
  - Reset mid-edge discards the edge with no further samples.
- States: IDLE, EMIT.
- IDLE:
  - edge_ready=1, pose_valid=0.
  - On edge_valid=1, at that clock edge, capture per joint:
    - delta_j = goal_j - start_j, signed 33-bit, no overflow.
    - acc_j = start_j << STEP_SHIFT, signed 33+STEP_SHIFT bits.
  - Same edge: stepperPosition <= startPose, pose_idx <= 0, pose_last <= 0, go to EMIT.
  - Latency: edge accepted at cycle t; first sample valid at t+1.
- EMIT:
  - edge_ready=0, busy=1, pose_valid=1.
  - stepperPosition, pose_idx and pose_last stay stable while pose_valid=1 and pose_ready=0.
  - edge_valid is ignored in EMIT.
  - On pose_valid & pose_ready, if pose_last=1: go to IDLE (pose_valid=0 next cycle; no bubble requirement on the next edge).
  - On pose_valid & pose_ready, otherwise:
    - acc_j += delta_j.
    - stepperPosition_j <= (acc_j + delta_j) >>> STEP_SHIFT (arithmetic shift, low 32 bits).
    - pose_idx += 1.
    - pose_last <= (new pose_idx == 2^STEP_SHIFT).
  - Throughput: one sample per cycle while pose_ready=1.
- Arithmetic:
  - Sample k per joint = floor((start*2^S + k*delta) / 2^S), exactly, with floor toward -inf.
  - Sample 0 = start exactly; sample 2^S = goal exactly.
  - The accumulator never overflows for any 32-bit start/goal pair.
- abort:
  - Abort in EMIT: next state IDLE, pose_valid=0 next cycle, no more samples.
  - Abort has priority over a simultaneous handshake: a sample accepted in the abort cycle is the last one delivered.
  - Abort in IDLE has no effect, and edge_valid in that cycle is still accepted.
- Degenerate edge (start==goal): emits 2^S+1 identical samples; no shortcut.
- Joints are independent; there is no cross-joint carry.

Test Plan:
- Reset: assert RST mid-EMIT asynchronously -> same cycle pose_valid=0, edge_ready=1, busy=0, stepperPosition=0; after release, a new edge is accepted normally.
- S=4, joint0 start=0 goal=160, other joints 7->7, pose_ready=1 -> 17 samples on consecutive cycles: joint0=0,10,...,160; other joints=7; pose_idx 0..16; pose_last only on idx 16; first pose_valid one cycle after edge accept.
- Negative and non-divisible delta:
  - start=100 goal=-60 -> 100,90,...,-60.
  - start=0 goal=5 -> 0,0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5.
  - start=-1 goal=0 -> -1 for k<16, 0 at k=16.
- Extremes: start=0x7FFFFFFF goal=0x80000000 -> sample0=0x7FFFFFFF, sample16=0x80000000, intermediates monotonically decreasing as signed values, no wrap.
- Backpressure: toggle pose_ready randomly -> stepperPosition/pose_idx/pose_last stable while stalled; the exact sequence of 17 accepted samples is unchanged; edge_valid pulses during EMIT are ignored and edge_ready stays 0.
- Abort: assert abort together with pose_ready on idx 5 -> idx 5 is the last sample delivered, pose_valid=0 next cycle, edge_ready=1; a following edge restarts at idx 0 with the new start pose.
